// File: rtl/multicycle_ctrl.sv
// Main control FSM, ALU decoder, flag-write and PC-select for the multicycle ARM-subset core,
// with a multiply stall and an FPU start/done handshake. Define CTRL_PERF_CNT_EN for perf counters.
module multicycle_ctrl #(
  parameter int MUL_LAT     = 3,
  parameter int FPU_TIMEOUT = 16,
  parameter int ALUCTL_W    = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [1:0]          Op,
  input  logic [5:0]          Funct,
  input  logic [3:0]          Rd,
  input  logic [3:0]          Mul,
  input  logic                fpu_done,
  output logic [1:0]          FlagW,
  output logic                PCS,
  output logic                NextPC,
  output logic                RegW,
  output logic                MemW,
  output logic                FPUW,
  output logic                IRWrite,
  output logic                AdrSrc,
  output logic [1:0]          ResultSrc,
  output logic [1:0]          ALUSrcA,
  output logic [1:0]          ALUSrcB,
  output logic [1:0]          ImmSrc,
  output logic [1:0]          RegSrc,
  output logic [ALUCTL_W-1:0] ALUControl,
  output logic                fpu_start,
  output logic                fpu_err,
  output logic                busy,
  output logic [31:0]         perf_cycles,
  output logic [31:0]         perf_retired
);

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXECUTER, S_EXECUTEI, S_MULWAIT, S_ALUWB, S_MEMADR,
    S_MEMRD, S_MEMWB, S_MEMWR, S_BRANCH, S_FPUEXEC, S_FPUWAIT, S_FPUWB
  } state_t;

  localparam int MUL_CNT_W = (MUL_LAT > 2) ? $clog2(MUL_LAT - 1) : 1;
  localparam int FPU_CNT_W = $clog2(FPU_TIMEOUT);
  localparam logic [MUL_CNT_W-1:0] MUL_LOAD = (MUL_LAT > 2) ? MUL_CNT_W'(MUL_LAT - 2) : '0;
  localparam logic [FPU_CNT_W-1:0] FPU_LAST = FPU_CNT_W'(FPU_TIMEOUT - 1);
  localparam bit MUL_STALL = (MUL_LAT > 1);

  state_t                 r_state, w_next;
  logic [MUL_CNT_W-1:0]   r_mul_cnt;
  logic [FPU_CNT_W-1:0]   r_fpu_cnt;
  logic                   r_fpu_err;
  logic                   w_alu_op, w_branch, w_last_exec, w_mul_stall, w_fpu_timeout;
  logic [2:0]             w_alu_dec;

  assign w_mul_stall   = MUL_STALL && (Mul == 4'b1001);
  assign w_fpu_timeout = (r_state == S_FPUWAIT) && !fpu_done && (r_fpu_cnt == FPU_LAST);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_mul_cnt <= '0;
      r_fpu_cnt <= '0;
      r_fpu_err <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == S_EXECUTER)
        r_mul_cnt <= MUL_LOAD;
      else if (r_state == S_MULWAIT && r_mul_cnt != '0)
        r_mul_cnt <= r_mul_cnt - MUL_CNT_W'(1);
      if (r_state == S_FPUEXEC)
        r_fpu_cnt <= '0;
      else if (r_state == S_FPUWAIT)
        r_fpu_cnt <= r_fpu_cnt + FPU_CNT_W'(1);
      if (w_fpu_timeout)
        r_fpu_err <= 1'b1;
    end
  end

  // NOTE: every output gets a default first so no path through the case can infer a latch.
  always_comb begin
    w_next      = r_state;
    NextPC      = 1'b0;
    RegW        = 1'b0;
    MemW        = 1'b0;
    FPUW        = 1'b0;
    IRWrite     = 1'b0;
    AdrSrc      = 1'b0;
    ResultSrc   = 2'b00;
    ALUSrcA     = 2'b00;
    ALUSrcB     = 2'b00;
    fpu_start   = 1'b0;
    w_alu_op    = 1'b0;
    w_branch    = 1'b0;
    w_last_exec = 1'b0;
    case (r_state)
      S_IDLE:   w_next = S_FETCH;
      S_FETCH: begin
        IRWrite = 1'b1; NextPC = 1'b1;
        ALUSrcA = 2'b01; ALUSrcB = 2'b10; ResultSrc = 2'b10;
        w_next  = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcA = 2'b01; ALUSrcB = 2'b10; ResultSrc = 2'b10;
        case (Op)
          2'b00:   w_next = Funct[5] ? S_EXECUTEI : S_EXECUTER;
          2'b01:   w_next = S_MEMADR;
          2'b10:   w_next = S_BRANCH;
          default: w_next = S_FPUEXEC;
        endcase
      end
      S_EXECUTER: begin
        w_alu_op = 1'b1;
        if (w_mul_stall) begin
          w_next = S_MULWAIT;
        end else begin
          w_last_exec = 1'b1;
          w_next      = S_ALUWB;
        end
      end
      S_EXECUTEI: begin
        w_alu_op = 1'b1; ALUSrcB = 2'b01; w_last_exec = 1'b1;
        w_next   = S_ALUWB;
      end
      S_MULWAIT: begin
        w_alu_op = 1'b1;
        if (r_mul_cnt == '0) begin
          w_last_exec = 1'b1;
          w_next      = S_ALUWB;
        end
      end
      S_ALUWB:  begin RegW = 1'b1; w_next = S_FETCH; end
      S_MEMADR: begin ALUSrcB = 2'b01; w_next = Funct[0] ? S_MEMRD : S_MEMWR; end
      S_MEMRD:  begin AdrSrc = 1'b1; w_next = S_MEMWB; end
      S_MEMWB:  begin ResultSrc = 2'b01; RegW = 1'b1; w_next = S_FETCH; end
      S_MEMWR:  begin AdrSrc = 1'b1; MemW = 1'b1; w_next = S_FETCH; end
      S_BRANCH: begin
        ALUSrcA = 2'b10; ALUSrcB = 2'b01; ResultSrc = 2'b10; w_branch = 1'b1;
        w_next  = S_FETCH;
      end
      S_FPUEXEC: begin fpu_start = 1'b1; w_next = S_FPUWAIT; end
      S_FPUWAIT: begin
        if (fpu_done)            w_next = S_FPUWB;
        else if (w_fpu_timeout)  w_next = S_FETCH;
      end
      S_FPUWB:  begin FPUW = 1'b1; w_next = S_FETCH; end
      default:  w_next = S_IDLE;
    endcase
  end

  // MUL wins over the Funct decode only when Funct selects the AND slot.
  always_comb begin
    w_alu_dec = 3'b000;
    if (Mul == 4'b1001 && Funct[4:1] == 4'b0000) begin
      w_alu_dec = 3'b101;
    end else begin
      case (Funct[4:1])
        4'b0100: w_alu_dec = 3'b000;
        4'b0010: w_alu_dec = 3'b001;
        4'b0000: w_alu_dec = 3'b010;
        4'b1100: w_alu_dec = 3'b011;
        4'b0001: w_alu_dec = 3'b100;
        default: w_alu_dec = 3'b000;
      endcase
    end
  end

  always_comb begin
    ALUControl = '0;
    FlagW      = 2'b00;
    if (w_alu_op)
      ALUControl[2:0] = w_alu_dec;
    if (w_alu_op && w_last_exec)
      FlagW = {Funct[0], Funct[0] & (w_alu_dec == 3'b000 || w_alu_dec == 3'b001)};
  end

  assign PCS     = ((Rd == 4'hF) & RegW) | w_branch | ((Rd == 4'hF) & FPUW);
  assign ImmSrc  = (r_state == S_IDLE) ? 2'b00 : Op;
  assign RegSrc  = (r_state == S_IDLE) ? 2'b00 : {Op == 2'b01, Op == 2'b10};
  assign fpu_err = r_fpu_err;
  assign busy    = (r_state != S_IDLE) && (r_state != S_FETCH);

`ifdef CTRL_PERF_CNT_EN
  logic [31:0] r_perf_cycles, r_perf_retired;
  logic        w_retire;

  // Timeout exits FPUWAIT straight to FETCH and is deliberately not a retirement.
  assign w_retire = (r_state == S_ALUWB) || (r_state == S_MEMWB) || (r_state == S_MEMWR) ||
                    (r_state == S_BRANCH) || (r_state == S_FPUWB);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_perf_cycles  <= 32'd0;
      r_perf_retired <= 32'd0;
    end else begin
      r_perf_cycles <= r_perf_cycles + 32'd1;
      if (w_retire)
        r_perf_retired <= r_perf_retired + 32'd1;
    end
  end

  assign perf_cycles  = r_perf_cycles;
  assign perf_retired = r_perf_retired;
`else
  assign perf_cycles  = 32'd0;
  assign perf_retired = 32'd0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: per-cycle vector table with a scoreboard queue;
// main instance uses MUL_LAT=3, FPU_TIMEOUT=16, ALUCTL_W=4; a second instance uses MUL_LAT=1.
module tb_multicycle_ctrl;

  typedef enum {T_IDLE, T_FETCH, T_DECODE, T_EXECUTER, T_EXECUTEI, T_MULWAIT, T_ALUWB, T_MEMADR,
                T_MEMRD, T_MEMWB, T_MEMWR, T_BRANCH, T_FPUEXEC, T_FPUWAIT, T_FPUWB} st_t;

  typedef struct packed {
    logic [1:0] flagw;
    logic       pcs, nextpc, regw, memw, fpuw, irwrite, adrsrc;
    logic [1:0] resultsrc, alusrca, alusrcb, immsrc, regsrc;
    logic [3:0] aluctl;
    logic       fpu_start, fpu_err, busy;
  } outs_t;

  typedef struct {
    string      name;
    bit         rst, m1, done;
    logic [1:0] op;
    logic [5:0] funct;
    logic [3:0] rd, mul;
    st_t        st;
    logic [2:0] alu;
    logic [1:0] fw;
    bit         pcs, err;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [1:0] Op = 2'b00;
  logic [5:0] Funct = 6'd0;
  logic [3:0] Rd = 4'd0, Mul = 4'd0;
  logic fpu_done = 1'b0;

  logic [1:0] FlagW, ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, RegSrc;
  logic PCS, NextPC, RegW, MemW, FPUW, IRWrite, AdrSrc, fpu_start, fpu_err, busy;
  logic [3:0] ALUControl;
  logic [31:0] perf_cycles, perf_retired;

  logic [1:0] m1_FlagW, m1_ResultSrc, m1_ALUSrcA, m1_ALUSrcB, m1_ImmSrc, m1_RegSrc;
  logic m1_PCS, m1_NextPC, m1_RegW, m1_MemW, m1_FPUW, m1_IRWrite, m1_AdrSrc;
  logic m1_fpu_start, m1_fpu_err, m1_busy;
  logic [2:0] m1_ALUControl;
  logic [31:0] m1_perf_cycles, m1_perf_retired;

  outs_t act_main, act_m1;
  vec_t  tbl[$];
  outs_t sb[$];
  int    tests = 0, failed = 0;
  int    exp_cyc = 0, exp_ret = 0;
  st_t   prev_st = T_IDLE;

  string      cur_name;
  logic [1:0] cur_op;
  logic [5:0] cur_funct;
  logic [3:0] cur_rd, cur_mul;
  bit         cur_err = 1'b0, cur_m1 = 1'b0;

  always #5 clk = ~clk;

  multicycle_ctrl #(.MUL_LAT(3), .FPU_TIMEOUT(16), .ALUCTL_W(4)) dut (
    .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .Rd(Rd), .Mul(Mul), .fpu_done(fpu_done),
    .FlagW(FlagW), .PCS(PCS), .NextPC(NextPC), .RegW(RegW), .MemW(MemW), .FPUW(FPUW),
    .IRWrite(IRWrite), .AdrSrc(AdrSrc), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc), .RegSrc(RegSrc), .ALUControl(ALUControl),
    .fpu_start(fpu_start), .fpu_err(fpu_err), .busy(busy),
    .perf_cycles(perf_cycles), .perf_retired(perf_retired));

  multicycle_ctrl #(.MUL_LAT(1), .FPU_TIMEOUT(16), .ALUCTL_W(3)) dut_m1 (
    .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .Rd(Rd), .Mul(Mul), .fpu_done(fpu_done),
    .FlagW(m1_FlagW), .PCS(m1_PCS), .NextPC(m1_NextPC), .RegW(m1_RegW), .MemW(m1_MemW),
    .FPUW(m1_FPUW), .IRWrite(m1_IRWrite), .AdrSrc(m1_AdrSrc), .ResultSrc(m1_ResultSrc),
    .ALUSrcA(m1_ALUSrcA), .ALUSrcB(m1_ALUSrcB), .ImmSrc(m1_ImmSrc), .RegSrc(m1_RegSrc),
    .ALUControl(m1_ALUControl), .fpu_start(m1_fpu_start), .fpu_err(m1_fpu_err), .busy(m1_busy),
    .perf_cycles(m1_perf_cycles), .perf_retired(m1_perf_retired));

  always_comb begin
    act_main = {FlagW, PCS, NextPC, RegW, MemW, FPUW, IRWrite, AdrSrc, ResultSrc, ALUSrcA,
                ALUSrcB, ImmSrc, RegSrc, ALUControl, fpu_start, fpu_err, busy};
    act_m1   = {m1_FlagW, m1_PCS, m1_NextPC, m1_RegW, m1_MemW, m1_FPUW, m1_IRWrite, m1_AdrSrc,
                m1_ResultSrc, m1_ALUSrcA, m1_ALUSrcB, m1_ImmSrc, m1_RegSrc, 1'b0, m1_ALUControl,
                m1_fpu_start, m1_fpu_err, m1_busy};
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Moore outputs expected in each state; data-dependent fields are filled from the row.
  function automatic outs_t base(st_t st, logic [1:0] op);
    outs_t o = '0;
    if (st != T_IDLE) begin
      o.immsrc = op;
      o.regsrc = {op == 2'b01, op == 2'b10};
      o.busy   = (st != T_FETCH);
    end
    case (st)
      T_FETCH:    begin o.irwrite = 1; o.nextpc = 1; o.alusrca = 2'b01; o.alusrcb = 2'b10; o.resultsrc = 2'b10; end
      T_DECODE:   begin o.alusrca = 2'b01; o.alusrcb = 2'b10; o.resultsrc = 2'b10; end
      T_EXECUTEI: o.alusrcb = 2'b01;
      T_ALUWB:    o.regw = 1;
      T_MEMADR:   o.alusrcb = 2'b01;
      T_MEMRD:    o.adrsrc = 1;
      T_MEMWB:    begin o.resultsrc = 2'b01; o.regw = 1; end
      T_MEMWR:    begin o.adrsrc = 1; o.memw = 1; end
      T_BRANCH:   begin o.alusrca = 2'b10; o.alusrcb = 2'b01; o.resultsrc = 2'b10; end
      T_FPUEXEC:  o.fpu_start = 1;
      T_FPUWB:    o.fpuw = 1;
      default:    ;
    endcase
    return o;
  endfunction

  function automatic void instr(string n, logic [1:0] op, logic [5:0] f, logic [3:0] rd, logic [3:0] mul);
    cur_name = n; cur_op = op; cur_funct = f; cur_rd = rd; cur_mul = mul;
  endfunction

  function automatic void add(st_t st, logic [2:0] alu = 3'b000, logic [1:0] fw = 2'b00,
                              bit pcs = 1'b0, bit done = 1'b0, bit rst = 1'b1);
    vec_t v;
    v.name = cur_name; v.op = cur_op; v.funct = cur_funct; v.rd = cur_rd; v.mul = cur_mul;
    v.rst = rst; v.m1 = cur_m1; v.done = done; v.st = st; v.alu = alu; v.fw = fw;
    v.pcs = pcs; v.err = cur_err;
    tbl.push_back(v);
  endfunction

  task automatic run_row(input vec_t v, input int idx);
    outs_t e, a;
    string nm;
    reset = v.rst; Op = v.op; Funct = v.funct; Rd = v.rd; Mul = v.mul; fpu_done = v.done;
    e = base(v.st, v.op);
    e.aluctl = {1'b0, v.alu}; e.flagw = v.fw; e.pcs = v.pcs; e.fpu_err = v.err;
    sb.push_back(e);
    if (!v.m1) begin
      if (v.st == T_IDLE) begin
        exp_cyc = 0; exp_ret = 0;
      end else begin
        exp_cyc++;
        if (v.st == T_FETCH && prev_st inside {T_ALUWB, T_MEMWB, T_MEMWR, T_BRANCH, T_FPUWB})
          exp_ret++;
      end
      prev_st = v.st;
    end
    #1;
    nm = $sformatf("%s/%s#%0d", v.name, v.st.name(), idx);
    a  = v.m1 ? act_m1 : act_main;
    e  = sb.pop_front();
    check(nm, 32'(a), 32'(e));
    if (!v.m1) begin
`ifdef CTRL_PERF_CNT_EN
      check({nm, "/perf_cycles"}, perf_cycles, exp_cyc);
      check({nm, "/perf_retired"}, perf_retired, exp_ret);
`else
      check({nm, "/perf_cycles"}, perf_cycles, 32'd0);
      check({nm, "/perf_retired"}, perf_retired, 32'd0);
`endif
    end
    @(negedge clk);
  endtask

  initial begin
    // Reset, then ADD reg: 5 cycles IDLE..ALUWB from release.
    instr("add", 2'b00, 6'b001000, 4'd2, 4'b0000);
    add(T_IDLE, 3'b000, 2'b00, 1'b0, 1'b0, 1'b0);
    add(T_IDLE); add(T_FETCH); add(T_DECODE); add(T_EXECUTER, 3'b000, 2'b00); add(T_ALUWB);
    instr("subs_pc", 2'b00, 6'b100101, 4'd15, 4'b0000);
    add(T_FETCH); add(T_DECODE); add(T_EXECUTEI, 3'b001, 2'b11); add(T_ALUWB, 3'b000, 2'b00, 1'b1);
    // MULS: flags only in the final MULWAIT cycle; MUL is not an add/sub so C/V stays off.
    instr("muls", 2'b00, 6'b000001, 4'd3, 4'b1001);
    add(T_FETCH); add(T_DECODE); add(T_EXECUTER, 3'b101, 2'b00);
    add(T_MULWAIT, 3'b101, 2'b00); add(T_MULWAIT, 3'b101, 2'b10); add(T_ALUWB);
    instr("orrs", 2'b00, 6'b011001, 4'd1, 4'b0000);
    add(T_FETCH); add(T_DECODE); add(T_EXECUTER, 3'b011, 2'b10); add(T_ALUWB);
    instr("eor_i", 2'b00, 6'b100010, 4'd7, 4'b0110);
    add(T_FETCH); add(T_DECODE); add(T_EXECUTEI, 3'b100, 2'b00); add(T_ALUWB);
    instr("ldr", 2'b01, 6'b011001, 4'd4, 4'b0000);
    add(T_FETCH); add(T_DECODE); add(T_MEMADR); add(T_MEMRD); add(T_MEMWB);
    instr("str", 2'b01, 6'b011000, 4'd4, 4'b0000);
    add(T_FETCH); add(T_DECODE); add(T_MEMADR); add(T_MEMWR);
    instr("b", 2'b10, 6'b101000, 4'd0, 4'b0000);
    add(T_FETCH); add(T_DECODE); add(T_BRANCH, 3'b000, 2'b00, 1'b1);
    // FPU to PC: stray done in FPUEXEC is ignored, real done on the 4th FPUWAIT cycle.
    instr("fpu_done", 2'b11, 6'b000000, 4'd15, 4'b0000);
    add(T_FETCH); add(T_DECODE); add(T_FPUEXEC, 3'b000, 2'b00, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) add(T_FPUWAIT);
    add(T_FPUWAIT, 3'b000, 2'b00, 1'b0, 1'b1);
    add(T_FPUWB, 3'b000, 2'b00, 1'b1);
    instr("fpu_tmo", 2'b11, 6'b000000, 4'd6, 4'b0000);
    add(T_FETCH); add(T_DECODE); add(T_FPUEXEC);
    for (int i = 0; i < 16; i++) add(T_FPUWAIT);
    cur_err = 1'b1;
    // Abort during MULWAIT: async reset clears everything including the sticky error.
    instr("mul_rst", 2'b00, 6'b000000, 4'd3, 4'b1001);
    add(T_FETCH); add(T_DECODE); add(T_EXECUTER, 3'b101); add(T_MULWAIT, 3'b101);
    cur_err = 1'b0;
    add(T_IDLE, 3'b000, 2'b00, 1'b0, 1'b0, 1'b0);
    add(T_IDLE); add(T_FETCH); add(T_DECODE);
    // MUL_LAT=1 instance: EXECUTER is the last execute cycle and goes straight to ALUWB.
    cur_m1 = 1'b1;
    instr("muls_lat1", 2'b00, 6'b000001, 4'd3, 4'b1001);
    add(T_IDLE, 3'b000, 2'b00, 1'b0, 1'b0, 1'b0);
    add(T_IDLE); add(T_FETCH); add(T_DECODE); add(T_EXECUTER, 3'b101, 2'b10); add(T_ALUWB); add(T_FETCH);

    @(negedge clk);
    for (int i = 0; i < tbl.size(); i++) begin
      vec_t v;
      v = tbl[i];
      if (v.rst == 1'b0 && i > 0)
        #2;
      run_row(v, i);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
Parametrised successor to the multicycle decode unit: main control FSM, ALU decoder, flag-write and PC-select logic for the ARM-subset multicycle core.
Adds a configurable multi-cycle multiply stall and a start/done handshake to an external FPU with timeout.
Sits between the instruction register (Op/Funct/Rd/Mul fields) and the datapath muxes/enables.

Parameters:
MUL_LAT, 3, multiply latency in cycles (>=1); EXECUTER->ALUWB path for MUL takes MUL_LAT cycles
FPU_TIMEOUT, 16, max cycles in FPUWAIT before abort (>=2)
ALUCTL_W, 3, ALUControl width (>=3; upper bits zero)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
Op  in  2  instr[27:26]
Funct  in  6  instr[25:20]
Rd  in  4  instr[15:12]
Mul  in  4  instr[7:4]
fpu_done  in  1  FPU result valid, single-cycle pulse
FlagW  out  2  [1]=NZ write, [0]=CV write
PCS  out  1  PC source select
NextPC  out  1  PC write enable
RegW  out  1  register file write
MemW  out  1  memory write
FPUW  out  1  FPU result write to register file
IRWrite  out  1  instruction register enable
AdrSrc  out  1  0=PC, 1=ALU result
ResultSrc  out  2  00 ALUOut, 01 Data, 10 ALUResult
ALUSrcA  out  2  00 Rn, 01 PC, 10 ALUOut
ALUSrcB  out  2  00 Rm, 01 ExtImm, 10 const 4
ImmSrc  out  2  = Op
RegSrc  out  2  [1]=(Op==01), [0]=(Op==10)
ALUControl  out  ALUCTL_W  ALU operation
fpu_start  out  1  one-cycle FPU launch pulse
fpu_err  out  1  sticky FPU timeout flag
busy  out  1  high in every state except FETCH/IDLE
perf_cycles  out  32  cycle counter (optional feature)
perf_retired  out  32  retired-instruction counter (optional feature)

Behaviour:
- Reset (reset==0, async): state=IDLE, counters 0, fpu_err=0. In IDLE all enables (NextPC, RegW, MemW, FPUW, IRWrite, fpu_start) = 0, muxes = 0, ALUControl=0, FlagW=0. IDLE -> FETCH unconditionally on the first edge after release.
- Moore outputs per state. FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=01, ALUSrcB=10, ResultSrc=10, NextPC=1 -> DECODE.
- DECODE: ALUSrcA=01, ALUSrcB=10, ResultSrc=10. Op=00: Funct[5] ? EXECUTEI : EXECUTER. Op=01 -> MEMADR. Op=10 -> BRANCH. Op=11 -> FPUEXEC.
- EXECUTER/EXECUTEI: ALUSrcA=00, ALUSrcB=00/01, ALUOp=1. EXECUTER with Mul==1001 and MUL_LAT>1 -> MULWAIT; otherwise -> ALUWB.
- MULWAIT: down-counter loaded with MUL_LAT-2 on entry; ALUOp held; -> ALUWB when count==0. Total EXECUTER..ALUWB-entry = MUL_LAT cycles.
- ALUWB: ResultSrc=00, RegW=1 -> FETCH. MEMADR: ALUSrcB=01, ALUOp=0. Funct[0] ? MEMRD : MEMWR. MEMRD: AdrSrc=1 -> MEMWB. MEMWB: ResultSrc=01, RegW=1 -> FETCH. MEMWR: AdrSrc=1, MemW=1 -> FETCH.
- BRANCH: ALUSrcA=10, ALUSrcB=01, ResultSrc=10, Branch=1 -> FETCH.
- FPUEXEC: fpu_start=1 for exactly this cycle -> FPUWAIT. FPUWAIT: timeout counter from 0. fpu_done=1 -> FPUWB. Counter reaching FPU_TIMEOUT-1 without done -> set fpu_err, -> FETCH, no write. fpu_done outside FPUWAIT is ignored. FPUWB: FPUW=1 -> FETCH.
- ALU decoder (ALUOp=1): Mul==1001 and Funct[4:1]==0000 -> 101 (MUL). Otherwise Funct[4:1]: 0100->000 ADD, 0010->001 SUB, 0000->010 AND, 1100->011 ORR, 0001->100 EOR, other->000. ALUOp=0 -> 000.
- FlagW: ALUOp=1 gives FlagW[1]=Funct[0] and FlagW[0]=Funct[0]&(ALUControl is 000 or 001); else 00. FlagW is asserted only in the last execute cycle (EXECUTER/EXECUTEI when not entering MULWAIT, or the final MULWAIT cycle).
- PCS = ((Rd==1111)&RegW) | Branch | ((Rd==1111)&FPUW).
- fpu_err is cleared only by reset. busy = state not in {IDLE, FETCH}.
- Reset mid-instruction aborts immediately. No pending write or fpu_start may appear after release.

Optional Feature:
CTRL_PERF_CNT_EN
- Defined: perf_cycles increments every cycle out of reset. perf_retired increments on entry to FETCH from ALUWB, MEMWB, MEMWR, BRANCH or FPUWB; an FPU timeout does not count. Both wrap at 2^32 and clear on reset.
- Undefined: both ports tie to 0 and no counter flops are built.

Test Plan:
- Reset release, then ADD reg (Op=00, Funct=001000, Rd=2) -> IDLE, FETCH, DECODE, EXECUTER (ALUControl=000, FlagW=00), ALUWB (RegW=1, PCS=0); 5 cycles from reset release.
- SUBS imm to Rd=15 (Funct=100101) -> EXECUTEI shows ALUControl=001, FlagW=11; ALUWB shows RegW=1, PCS=1.
- MUL (Mul=1001, Funct=000000), MUL_LAT=3 -> EXECUTER + 2 MULWAIT cycles with ALUControl=101, then ALUWB. With MUL_LAT=1 -> direct EXECUTER->ALUWB.
- LDR (Op=01, Funct[0]=1) -> MEMADR, MEMRD (AdrSrc=1), MEMWB (ResultSrc=01, RegW=1). STR -> MEMWR with MemW=1 for exactly 1 cycle.
- FPU op, fpu_done at 4th FPUWAIT cycle -> one fpu_start pulse, FPUWB with FPUW=1. No done, FPU_TIMEOUT=16 -> 16 FPUWAIT cycles, fpu_err=1, FETCH, FPUW never asserted.
- reset asserted during MULWAIT -> all outputs 0 asynchronously, then IDLE->FETCH on release. With CTRL_PERF_CNT_EN, perf_retired==0 after reset.
